// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: pipeline request/response and data_mem strobe bundle for dmem_access_ctrl
interface dmem_access_ctrl_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic [3:0]  req_sign_mask;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_sign_mask;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [31:0] mem_read_data;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_sign_mask, mem_read_data,
    input  stall, resp_valid, resp_rdata, fault, mem_addr, mem_write_data, mem_sign_mask,
           mem_memread, mem_memwrite
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_sign_mask, mem_read_data,
    output stall, resp_valid, resp_rdata, fault, mem_addr, mem_write_data, mem_sign_mask,
           mem_memread, mem_memwrite
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences one-cycle data_mem strobes for held MEM-stage requests and stalls until done.
// Optional access checking enabled by defining DMEM_ACCESS_CTRL_FAULT_CHECK_EN.
module dmem_access_ctrl #(
  parameter logic [31:0] DMEM_BASE  = 32'h0000_1000,
  parameter logic [31:0] DMEM_BYTES = 32'd4096,
  parameter logic [31:0] LED_ADDR   = 32'h0000_2000,
  parameter int          READ_WAIT  = 1
) (
  input logic clk,
  input logic rst,
  dmem_access_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam int CW = $clog2(READ_WAIT) + 1;
  state_t r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0] r_mask;
  logic [CW-1:0] r_cnt;
  logic r_write, w_rej, w_accept;
  assign w_accept = r_state == IDLE && bus.req_valid;
`ifdef DMEM_ACCESS_CTRL_FAULT_CHECK_EN
  logic [31:0] w_off;
  logic w_mis, w_in, w_led, r_rej;
  assign w_off = bus.req_addr - DMEM_BASE;
  assign w_in = w_off < DMEM_BYTES;
  assign w_mis = bus.req_size == 2'b01 ? bus.req_addr[0] : bus.req_size[1] & |bus.req_addr[1:0];
  assign w_led = bus.req_write && bus.req_addr == LED_ADDR;
  assign w_rej = w_mis | (!w_in & !w_led);
  always_ff @(posedge clk) begin
    if (rst) r_rej <= 1'b0;
    else if (w_accept) r_rej <= w_rej;
  end
  assign bus.fault = r_state == DONE && r_rej;
`else
  logic w_unused;
  assign w_unused = &{1'b0, bus.req_size};
  assign w_rej = 1'b0;
  assign bus.fault = 1'b0;
`endif
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    bus.stall = 1'b1;
    case (r_state)
      IDLE: begin
        bus.stall = bus.req_valid;
        w_next = !bus.req_valid ? IDLE : w_rej ? DONE : ISSUE;
      end
      ISSUE: w_next = r_write ? DONE : WAIT;
      WAIT: w_next = r_cnt == '0 ? DONE : WAIT;
      DONE: begin
        bus.stall = 1'b0;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_wdata <= '0;
      r_mask <= '0;
      r_write <= 1'b0;
      r_cnt <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_mask <= bus.req_sign_mask;
        r_write <= bus.req_write;
        if (w_rej) r_rdata <= '0;
      end
      if (r_state == ISSUE) r_cnt <= CW'(READ_WAIT - 1);
      if (r_state == WAIT) begin
        if (r_cnt == '0) r_rdata <= bus.mem_read_data;
        else r_cnt <= r_cnt - 1'b1;
      end
    end
  end
  assign bus.mem_addr = r_addr;
  assign bus.mem_write_data = r_wdata;
  assign bus.mem_sign_mask = r_mask;
  assign bus.mem_memread = r_state == ISSUE && !r_write && !rst;
  assign bus.mem_memwrite = r_state == ISSUE && r_write && !rst;
  assign bus.resp_valid = r_state == DONE;
  assign bus.resp_rdata = r_rdata;
endmodule
